// File: rtl/conv_encoder_k3_if.sv
// Symbol/bit handshake bundle for the K=3 convolutional encoder.
// master: frame source and symbol sink; slave: the encoder itself.
interface conv_encoder_k3_if;
   logic       Start;
   logic       Data_In;
   logic       In_Valid;
   logic       In_Ready;
   logic [1:0] Encoded_Out;
   logic [1:0] PS_Out;
   logic [1:0] NS_Out;
   logic       Out_Valid;
   logic       Out_Ready;
   logic       Out_Last;
   logic       Busy;

   modport master (
      output Start, Data_In, In_Valid, Out_Ready,
      input  In_Ready, Encoded_Out, PS_Out, NS_Out,
      input  Out_Valid, Out_Last, Busy
   );

   modport slave (
      input  Start, Data_In, In_Valid, Out_Ready,
      output In_Ready, Encoded_Out, PS_Out, NS_Out,
      output Out_Valid, Out_Last, Busy
   );
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder (G0=111, G1=101), framed, zero-tailed.
// Ports: clk, reset (sync, active-high), enc (slave side of conv_encoder_k3_if).
module conv_encoder_k3 #(
   parameter int FRAME_LEN = 16
) (
   input  logic              clk,
   input  logic              reset,
   conv_encoder_k3_if.slave  enc
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_TAIL = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    r_d;       // {d1,d2}, d1 = most recent bit
   logic [CW-1:0] r_cnt;
   logic          r_tail;    // one tail symbol already issued
   logic [1:0]    r_enc;
   logic [1:0]    r_ps;
   logic [1:0]    r_ns;
   logic          r_vld;
   logic          r_last;

   logic w_free;
   logic w_acc;
   logic w_tgen;
   logic w_load;
   logic w_u;

   // Output slot can take a new symbol when empty or being drained.
   assign w_free = !r_vld || enc.Out_Ready;
   assign w_acc  = enc.In_Valid && (r_state == S_DATA) && w_free;
   assign w_tgen = (r_state == S_TAIL) && w_free;
   assign w_load = w_acc || w_tgen;
   // Tail symbols flush the register with zeros.
   assign w_u    = (r_state == S_DATA) ? enc.Data_In : 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_d     <= 2'b00;
         r_cnt   <= '0;
         r_tail  <= 1'b0;
         r_enc   <= 2'b00;
         r_ps    <= 2'b00;
         r_ns    <= 2'b00;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         if (w_load) begin
            r_enc  <= {w_u ^ r_d[1] ^ r_d[0], w_u ^ r_d[0]};
            r_ps   <= r_d;
            r_ns   <= {w_u, r_d[1]};
            r_d    <= {w_u, r_d[1]};
            r_vld  <= 1'b1;
            r_last <= w_tgen && r_tail;
         end else if (enc.Out_Ready) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (enc.Start) begin
                  r_state <= S_DATA;
                  r_cnt   <= '0;
               end
            end
            S_DATA: begin
               if (w_acc) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == LAST_IDX) begin
                     r_state <= S_TAIL;
                     r_tail  <= 1'b0;
                  end
               end
            end
            S_TAIL: begin
               if (w_tgen) begin
                  if (r_tail) begin
                     r_state <= S_IDLE;
                     r_tail  <= 1'b0;
                  end else begin
                     r_tail  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign enc.In_Ready    = (r_state == S_DATA) && w_free;
   assign enc.Encoded_Out = r_enc;
   assign enc.PS_Out      = r_ps;
   assign enc.NS_Out      = r_ns;
   assign enc.Out_Valid   = r_vld;
   assign enc.Out_Last    = r_last;
   assign enc.Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3 (FRAME_LEN=4 and FRAME_LEN=1).
// Expected symbols come from a frame-level trellis model pushed at Start.
module tb_conv_encoder_k3;

   localparam int FL = 4;

   typedef logic [6:0] sym_t; // {enc[1:0], ps[1:0], ns[1:0], last}

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   conv_encoder_k3_if e0 ();
   conv_encoder_k3_if e1 ();

   conv_encoder_k3 #(.FRAME_LEN(FL)) u_dut (
      .clk   (clk),
      .reset (reset),
      .enc   (e0.slave)
   );

   conv_encoder_k3 #(.FRAME_LEN(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .enc   (e1.slave)
   );

   sym_t q0[$];
   sym_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   bit   fb[64];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endfunction

   function automatic void tmo(string nm);
      checks++;
      errors++;
      $display("FAIL timeout_%s act=expired exp=event", nm);
   endfunction

   // Code sequence x = info bits followed by two zeros, starting from state 00.
   function automatic void model(input int n, input bit to1);
      for (int i = 0; i < n + 2; i++) begin
         bit u, d1, d2;
         sym_t s;
         u  = (i < n) ? fb[i] : 1'b0;
         d1 = (i >= 1 && i - 1 < n) ? fb[i-1] : 1'b0;
         d2 = (i >= 2 && i - 2 < n) ? fb[i-2] : 1'b0;
         s  = {u ^ d1 ^ d2, u ^ d2, d1, d2, u, d1, (i == n + 1)};
         if (to1) q1.push_back(s);
         else q0.push_back(s);
      end
   endfunction

   // Monitor: pops on every symbol handed downstream.
   sym_t pv0;
   bit   st0 = 1'b0;
   always @(negedge clk) begin
      sym_t a;
      sym_t b;
      a = {e0.Encoded_Out, e0.PS_Out, e0.NS_Out, e0.Out_Last};
      b = {e1.Encoded_Out, e1.PS_Out, e1.NS_Out, e1.Out_Last};
      if (reset) begin
         st0 = 1'b0;
      end else begin
         if (st0) begin
            chk("hold_valid", e0.Out_Valid, 1);
            chk("hold_payload", a, pv0);
         end
         if (e0.Out_Valid && e0.Out_Ready) begin
            if (q0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_symbol act=%0h exp=none", a);
            end else begin
               chk("symbol", a, q0.pop_front());
            end
         end
         st0 = e0.Out_Valid && !e0.Out_Ready;
         pv0 = a;
         if (e1.Out_Valid && e1.Out_Ready) begin
            if (q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_symbol_fl1 act=%0h exp=none", b);
            end else begin
               chk("symbol_fl1", b, q1.pop_front());
            end
         end
      end
   end

   // Downstream readiness, applied 2ns after each edge.
   initial begin
      e0.Out_Ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       e0.Out_Ready = 1'b1;
            1:       e0.Out_Ready = ($urandom_range(0, 2) != 0);
            default: e0.Out_Ready = 1'b0;
         endcase
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (e0.Busy) begin
         n++;
         if (n > 500) begin
            tmo("idle");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input bit b, input int gap);
      int n;
      repeat (gap) begin
         e0.In_Valid = 1'b0;
         e0.Data_In  = 1'($urandom);
         @(posedge clk);
         #1;
      end
      e0.In_Valid = 1'b1;
      e0.Data_In  = b;
      n = 0;
      @(negedge clk);
      while (!e0.In_Ready) begin
         n++;
         if (n > 500) begin
            tmo("in_ready");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      e0.In_Valid = 1'b0;
   endtask

   task automatic send_frame(input int n, input bit nowait,
                             input int maxgap, input bit spur);
      if (!nowait) wait_idle();
      e0.Start = 1'b1;
      @(posedge clk);
      #1;
      e0.Start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (spur && i == 1) e0.Start = 1'b1;
         send_bit(fb[i], $urandom_range(0, maxgap));
         e0.Start = 1'b0;
      end
      if (spur) begin
         e0.Start = 1'b1;
         @(posedge clk);
         #1;
         e0.Start = 1'b0;
      end
   endtask

   task automatic rand_fb(input int n);
      for (int i = 0; i < n; i++) fb[i] = 1'($urandom);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_valid"}, e0.Out_Valid, 0);
      chk({tag, "_enc"}, e0.Encoded_Out, 0);
      chk({tag, "_ps"}, e0.PS_Out, 0);
      chk({tag, "_ns"}, e0.NS_Out, 0);
      chk({tag, "_last"}, e0.Out_Last, 0);
      chk({tag, "_busy"}, e0.Busy, 0);
      chk({tag, "_in_ready"}, e0.In_Ready, 0);
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      e0.Start    = 1'b0;
      e0.Data_In  = 1'b0;
      e0.In_Valid = 1'b0;
      e1.Start    = 1'b0;
      e1.Data_In  = 1'b0;
      e1.In_Valid = 1'b0;
      e1.Out_Ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Known vector 1,0,1,1 with hand-derived symbols.
      fb[0] = 1; fb[1] = 0; fb[2] = 1; fb[3] = 1;
      q0.push_back({2'b11, 2'b00, 2'b10, 1'b0});
      q0.push_back({2'b10, 2'b10, 2'b01, 1'b0});
      q0.push_back({2'b00, 2'b01, 2'b10, 1'b0});
      q0.push_back({2'b01, 2'b10, 2'b11, 1'b0});
      q0.push_back({2'b01, 2'b11, 2'b01, 1'b0});
      q0.push_back({2'b11, 2'b01, 2'b00, 1'b1});
      send_frame(FL, 0, 0, 0);

      // In_Valid gaps.
      repeat (5) begin
         rand_fb(FL);
         model(FL, 0);
         send_frame(FL, 0, 3, 0);
      end

      // Spurious Start in DATA and TAIL.
      repeat (3) begin
         rand_fb(FL);
         model(FL, 0);
         send_frame(FL, 0, 1, 1);
      end

      // Reset on the 3rd bit.
      wait_idle();
      rand_fb(FL);
      model(FL, 0);
      e0.Start = 1'b1;
      @(posedge clk);
      #1;
      e0.Start = 1'b0;
      send_bit(fb[0], 0);
      send_bit(fb[1], 0);
      e0.In_Valid = 1'b1;
      e0.Data_In  = fb[2];
      reset = 1'b1;
      @(posedge clk);
      #1;
      e0.In_Valid = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      q0.delete();
      rand_fb(FL);
      model(FL, 0);
      send_frame(FL, 0, 0, 0);

      // Back-to-back frame with a pending Out_Last and 3 stalled cycles.
      rand_fb(FL);
      model(FL, 0);
      send_frame(FL, 0, 0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("b2b_last_loaded", {e0.Out_Valid, e0.Out_Last}, 2'b11);
      chk("b2b_idle", e0.Busy, 0);
      rdy_mode = 2;
      rand_fb(FL);
      model(FL, 0);
      fork
         send_frame(FL, 1, 0, 0);
         begin
            repeat (3) @(posedge clk);
            #1;
            rdy_mode = 0;
         end
      join

      // Random backpressure over 1000 bits.
      rdy_mode = 1;
      repeat (250) begin
         rand_fb(FL);
         model(FL, 0);
         send_frame(FL, 0, 1, 0);
      end
      rdy_mode = 0;
      n = 0;
      while (q0.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("drained", q0.size(), 0);

      // FRAME_LEN=1 instance.
      repeat (6) begin
         fb[0] = 1'($urandom);
         model(1, 1);
         n = 0;
         @(negedge clk);
         while (e1.Busy && n < 100) begin
            n++;
            @(negedge clk);
         end
         if (n >= 100) tmo("fl1_idle");
         @(posedge clk);
         #1;
         e1.Start = 1'b1;
         @(posedge clk);
         #1;
         e1.Start    = 1'b0;
         e1.In_Valid = 1'b1;
         e1.Data_In  = fb[0];
         n = 0;
         @(negedge clk);
         while (!e1.In_Ready && n < 100) begin
            n++;
            @(negedge clk);
         end
         if (n >= 100) tmo("fl1_in_ready");
         @(posedge clk);
         #1;
         e1.In_Valid = 1'b0;
      end
      n = 0;
      while (q1.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("drained_fl1", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "global timeout");
   end

endmodule
